// File: rtl/sha3_lane_fifo.sv
// Lane buffer between the SHA3 input interface and the absorb datapath, with {last, data} entries and a count of held messages.
// Define SHA3_FIFO_FWFT_EN for first-word-fall-through output; otherwise out_ready is a read strobe and the output is registered.
module sha3_lane_fifo #(
    parameter int WIDTH      = 64,
    parameter int DEPTH      = 32,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int AFULL_LVL  = DEPTH - 4,
    parameter int AEMPTY_LVL = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W:0]   msg_cnt,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0]   C_DEPTH  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   C_AFULL  = (ADDR_W+1)'(AFULL_LVL);
    localparam logic [ADDR_W:0]   C_AEMPTY = (ADDR_W+1)'(AEMPTY_LVL);
    localparam logic [ADDR_W:0]   C_ONE    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] C_PINC   = ADDR_W'(1);

    logic [WIDTH:0]    r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   r_msg_cnt;
    logic              r_overflow;
    logic              r_underflow;

    logic [WIDTH:0]    w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_wr_acc;
    logic              w_rd_acc;

    assign w_head   = r_mem[r_rd_ptr];
    assign w_full   = (r_count == C_DEPTH);
    assign w_empty  = (r_count == '0);
    // Full is judged before any same-cycle pop, so a pop never frees a slot for a simultaneous write.
    assign w_wr_acc = in_valid && !w_full && !flush;
    assign w_rd_acc = out_ready && !w_empty && !flush;

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= C_AFULL);
    assign almost_empty = (r_count <= C_AEMPTY);
    assign in_ready     = !w_full && !reset;
    assign count        = r_count;
    assign msg_cnt      = r_msg_cnt;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    always_ff @(posedge clk) begin
        if (!reset && w_wr_acc) begin
            r_mem[r_wr_ptr] <= {in_last, in_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_msg_cnt   <= '0;
            r_overflow  <= 1'b0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_msg_cnt   <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + C_PINC;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + C_PINC;
            if (w_wr_acc && !w_rd_acc)      r_count <= r_count + C_ONE;
            else if (!w_wr_acc && w_rd_acc) r_count <= r_count - C_ONE;
            if ((w_wr_acc && in_last) && !(w_rd_acc && w_head[WIDTH]))
                r_msg_cnt <= r_msg_cnt + C_ONE;
            else if (!(w_wr_acc && in_last) && (w_rd_acc && w_head[WIDTH]))
                r_msg_cnt <= r_msg_cnt - C_ONE;
            if (in_valid && w_full) r_overflow <= 1'b1;
        end
    end

`ifdef SHA3_FIFO_FWFT_EN
    // Head is gated while empty so the output reads zero after reset/flush rather than stale storage.
    assign out_valid   = !w_empty;
    assign out_data    = w_empty ? '0 : w_head[WIDTH-1:0];
    assign out_last    = !w_empty && w_head[WIDTH];
    assign r_underflow = 1'b0;
`else
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_last;
    logic             r_out_valid;

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_out_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_out_data <= w_head[WIDTH-1:0];
                r_out_last <= w_head[WIDTH];
            end
            if (out_ready && w_empty) r_underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/sha3_lane_fifo.md
# sha3_lane_fifo

Parametrised lane buffer between the SHA3 input interface and the absorb datapath. It carries WIDTH-bit lanes, each tagged with a last-of-message bit. The block adds valid/ready handshaking on both sides, programmable almost-full/almost-empty levels, a count of complete messages held, synchronous flush and sticky overflow/underflow flags. A compile-time option selects first-word-fall-through or registered-read output.

## Interface
- WIDTH, 64, lane width in bits
- DEPTH, 32, entries; must be a power of two, ≥ 2
- ADDR_W, $clog2(DEPTH), pointer width
- AFULL_LVL, DEPTH-4, almost_full asserts when count ≥ AFULL_LVL
- AEMPTY_LVL, 2, almost_empty asserts when count ≤ AEMPTY_LVL
- clk  in  1  single clock; all state is updated on its rising edge
- reset  in  1  asynchronous, active-high; clears all state
- flush  in  1  synchronous clear; has priority over write and read in the same cycle
- in_data  in  WIDTH  lane to write
- in_last  in  1  tag marking the final lane of a message
- in_valid  in  1  write request
- in_ready  out  1  equals !full; forced 0 while reset is high
- out_data  out  WIDTH  head lane
- out_last  out  1  tag belonging to out_data
- out_valid  out  1  output qualifier (meaning depends on mode, see Configuration)
- out_ready  in  1  pop request
- count  out  ADDR_W+1  entries held, range 0..DEPTH
- msg_cnt  out  ADDR_W+1  number of stored entries with last=1
- full, empty, almost_full, almost_empty  out  1 each  status flags
- overflow, underflow  out  1 each  sticky error flags

## Operation
- Storage: DEPTH × (WIDTH+1) array; each entry holds {last, data}.
- Pointers: wr_ptr and rd_ptr are ADDR_W bits wide and wrap modulo DEPTH. count is a separate register.
- Write accepted (wr_acc) when in_valid && !full. A write attempted while full is dropped and sets overflow. A read in the same cycle does not free the slot for that write.
- Pop (rd_acc) when out_ready && !empty. In registered mode, out_ready while empty sets underflow. In FWFT mode, out_ready while empty is legal and sets nothing.
- count: +1 on wr_acc only, −1 on rd_acc only, unchanged when both or neither occur.
- msg_cnt: +1 when a write with in_last=1 is accepted; −1 when a popped entry has last=1; both in the same cycle leave it unchanged.
- Flags are combinational from count: full=(count==DEPTH), empty=(count==0), almost_full=(count≥AFULL_LVL), almost_empty=(count≤AEMPTY_LVL).
- flush: wr_ptr, rd_ptr, count, msg_cnt, overflow, underflow and out_valid all go to 0. Array contents are not cleared. Write and read requests in the flush cycle are ignored.
- Reset: every register above goes to 0 and out_data/out_last go to 0. Flags after reset are empty=1, almost_empty=1, others 0.

## Timing
- Write to count/empty update: 1 cycle.
- FWFT mode: a lane written into an empty FIFO is presented with out_valid=1 on the cycle after the write.
- Registered mode: data appears 1 cycle after the pop request.
- Full FIFO: in_ready=0 on the cycle count reaches DEPTH. It returns to 1 one cycle after a pop.
- Sustained throughput: one write and one pop per cycle, at any count between 1 and DEPTH-1.
- Reset mid-operation: outputs take their reset values immediately (asynchronous). Operation resumes on the first clock edge after reset deasserts.

## Configuration
- SHA3_FIFO_FWFT_EN defined (FWFT mode):
  - out_valid = !empty.
  - out_data/out_last reflect the head entry combinationally.
  - A pop occurs on out_valid && out_ready.
- SHA3_FIFO_FWFT_EN undefined (registered-read mode):
  - out_ready acts as a read strobe.
  - On rd_acc, out_data/out_last are registered from the head entry and out_valid pulses high for exactly 1 cycle.
  - out_data holds its last value otherwise.

## Test plan
- Reset, then write 5 lanes (0x1..0x5, last on 0x5) → count=5, msg_cnt=1, almost_empty=0. Popping all 5 returns 0x1..0x5 in order with out_last only on 0x5; count and msg_cnt end at 0.
- Fill to DEPTH=32 → full=1 and in_ready=0. A 33rd write sets overflow=1 and count stays 32. Pop 1 → in_ready=1 on the next cycle.
- At count=10, simultaneous write and pop for 40 cycles → count stays 10 and pointers wrap. Data order is preserved across the wrap.
- Registered mode: pop on empty → underflow=1 and out_valid=0. FWFT mode: the same stimulus → underflow=0.
- At count=7, assert flush together with in_valid and out_ready → next cycle count=0, msg_cnt=0, error flags 0, out_valid=0.
- Assert reset asynchronously between edges at count=12 → count=0, empty=1 and out_valid=0 immediately, before the next clock edge.
